stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, clk cycles per counter tick (>=2).
REQ-002 SHALL have parameter SCAN_DIV, default 4, clk cycles per display digit slot (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  start/resume button level, already synchronous to clk.
REQ-006 SHALL have port stop  input  1  stop/clear button level, already synchronous to clk.
REQ-007 SHALL have port lap  input  1  lap-freeze toggle button level, already synchronous to clk.
REQ-008 SHALL have port ovf  input  1  datapath counter at maximum (99:59:99-style terminal value).
REQ-009 SHALL have port cnt_en  output  1  one-cycle count-increment strobe to the digit counter.
REQ-010 SHALL have port cnt_clr  output  1  hold digit counter at zero.
REQ-011 SHALL have port freeze  output  1  display latch hold (lap view).
REQ-012 SHALL have port state  output  2  FSM state code.
REQ-013 SHALL have port digit_idx  output  3  current scanned digit, 0..5.
REQ-014 SHALL have port seg_sel  output  6  one-hot active-high digit select, bit digit_idx set.

Function
REQ-015 SHALL detect a press as input=1 at this edge and registered previous sample=0; only presses, never levels, cause transitions.
REQ-016 SHALL implement states IDLE=00, RUN=01, PAUSE=10, LAP=11; the state output equals the current state register.
REQ-017 IDLE: start press -> RUN, prescaler=0; stop and lap presses ignored.
REQ-018 RUN: ovf=1 -> PAUSE; else stop press -> PAUSE; else lap press -> LAP; else start press ignored.
REQ-019 LAP: ovf=1 -> PAUSE; else stop press -> PAUSE; else lap press -> RUN.
REQ-020 PAUSE: stop press -> IDLE; else start press -> RUN with prescaler retained; lap ignored.
REQ-021 Simultaneous presses SHALL resolve by priority ovf > stop > lap > start.
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 wrapping in RUN/LAP, hold in PAUSE, and be forced to 0 in IDLE.
REQ-023 cnt_en SHALL be combinational: (state==RUN or LAP) and prescaler==TICK_DIV-1 and ovf==0.
REQ-024 First cnt_en after IDLE->RUN SHALL occur exactly TICK_DIV cycles after the transition edge, then every TICK_DIV cycles.
REQ-025 cnt_clr SHALL be 1 exactly when state==IDLE.
REQ-026 freeze SHALL be 1 exactly when state==LAP.
REQ-027 Scan divider SHALL free-run in all states; digit_idx advances every SCAN_DIV cycles, 0->1->...->5->0.
REQ-028 seg_sel SHALL equal 6'b1 shifted left by digit_idx, never zero or multi-hot.

Reset
REQ-029 While reset=1 at an edge: state=IDLE, prescaler=0, scan divider=0, digit_idx=0.
REQ-030 Previous-sample registers SHALL reset to 1, so a button held through reset release produces no press.
REQ-031 Outputs after reset: cnt_en=0, cnt_clr=1, freeze=0, state=00, seg_sel=6'b000001.
REQ-032 Reset asserted in any state, including mid-count, SHALL override all presses at that edge.

Verification
REQ-033 Reset, start pulse at cycle 3 -> state=01 next edge; cnt_en high 10 cycles later, then every 10 cycles; cnt_clr drops with RUN.
REQ-034 RUN with prescaler=6, stop press -> state=10, cnt_en stays 0; start press -> RUN, first cnt_en after 3 more cycles.
REQ-035 RUN, lap press -> state=11, freeze=1, cnt_en cadence unchanged; lap press -> state=01, freeze=0.
REQ-036 RUN, start+stop+lap same edge -> PAUSE; stop press -> IDLE, cnt_clr=1, prescaler=0.
REQ-037 RUN, ovf=1 at prescaler=9 -> cnt_en=0 that cycle, state=10 next edge; start held high through reset release -> state stays 00.
REQ-038 SCAN_DIV=4, free run 24 cycles -> seg_sel 000001,000010,...,100000, each held 4 cycles, then wraps to 000001.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch FSM (in: start/stop/lap/ovf; out: cnt_en, cnt_clr, freeze, state) plus 6-digit display scan (out: digit_idx, seg_sel)
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       ovf,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       freeze,
  output logic [1:0] state,
  output logic [2:0] digit_idx,
  output logic [5:0] seg_sel
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    dig_q, dig_d;
  logic          start_q, stop_q, lap_q;
  logic          start_p, stop_p, lap_p, counting, pre_wrap, scan_wrap;
  always_comb begin
    start_p   = start & ~start_q;
    stop_p    = stop & ~stop_q;
    lap_p     = lap & ~lap_q;
    counting  = state_q == RUN || state_q == LAP;
    pre_wrap  = pre_q == PW'(TICK_DIV - 1);
    scan_wrap = scan_q == SW'(SCAN_DIV - 1);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = start_p ? RUN : IDLE;
      RUN:     state_d = (ovf || stop_p) ? PAUSE : lap_p ? LAP : RUN;
      LAP:     state_d = (ovf || stop_p) ? PAUSE : lap_p ? RUN : LAP;
      default: state_d = stop_p ? IDLE : start_p ? RUN : PAUSE;
    endcase
    pre_d  = !counting ? (state_q == IDLE ? '0 : pre_q) : pre_wrap ? '0 : pre_q + 1'b1;
    scan_d = scan_wrap ? '0 : scan_q + 1'b1;
    dig_d  = !scan_wrap ? dig_q : dig_q == 3'd5 ? 3'd0 : dig_q + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      lap_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      start_q <= start;
      stop_q  <= stop;
      lap_q   <= lap;
    end
  end
  always_comb begin
    cnt_en    = counting && pre_wrap && !ovf;
    cnt_clr   = state_q == IDLE;
    freeze    = state_q == LAP;
    state     = state_q;
    digit_idx = dig_q;
    seg_sel   = 6'b000001 << dig_q;
  end
endmodule
